// File: rtl/bist_mac_pe.sv
// bist_mac_pe -- systolic-array MAC processing element with built-in self-test.
//
// Each cycle, outside self-test, the PE registers its activation (left_in) and
// its top operand (top_in). It multiplies the registered activation by either
// the stationary operand (stat_mode=1) or the low word of the registered top
// operand (stat_mode=0), and then accumulates the result:
//   stat_mode=1 : acc <= product + top_in_reg   (partial sum passes down)
//   stat_mode=0 : acc <= acc + product          (output-stationary)
// The product can be corrupted with a stuck-at fault mask, both in normal
// operation and during self-test.
//
// Self-test loads the stationary register with 3. It then accumulates
// 3*1 .. 3*N through the faulted product path and compares the sum with the
// closed-form golden value. A failing PE enters bypass: it forwards its
// operands unchanged so that the array around it keeps working.
//
// Ports
//   clk, rst              clock; asynchronous active-high reset
//   stat_mode             1 = weight/input-stationary, 0 = output-stationary
//   load_stat             load stat_reg from top_in[WORD_SIZE-1:0] (unregistered)
//   acc_clear             clear accumulator; takes priority over accumulation
//   out_sel               bottom_out: 0 = top_in_reg, 1 = acc_reg
//   left_in / right_out   activation in / registered activation out
//   top_in / bottom_out   operand or partial sum in / forwarded or result out
//   fi_en, fi_type, fi_mask   fault injection on the product (0 = SA0, 1 = SA1)
//   bist_start            start self-test (sampled while idle)
//   bist_busy, bist_done, bist_fail, bypass   self-test status
module bist_mac_pe #(
  parameter int WORD_SIZE    = 16,
  parameter int ACC_WIDTH    = 32,
  parameter int NUM_PATTERNS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stat_mode,
  input  logic                   load_stat,
  input  logic                   acc_clear,
  input  logic                   out_sel,
  input  logic [WORD_SIZE-1:0]   left_in,
  input  logic [ACC_WIDTH-1:0]   top_in,
  input  logic                   fi_en,
  input  logic                   fi_type,
  input  logic [2*WORD_SIZE-1:0] fi_mask,
  input  logic                   bist_start,
  output logic [WORD_SIZE-1:0]   right_out,
  output logic [ACC_WIDTH-1:0]   bottom_out,
  output logic                   bist_busy,
  output logic                   bist_done,
  output logic                   bist_fail,
  output logic                   bypass
);

  localparam int PW = 2 * WORD_SIZE;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  // Sum of 3*k for k = 1..N. NUM_PATTERNS <= 255 keeps this well inside int.
  localparam logic [ACC_WIDTH-1:0] GOLDEN =
    ACC_WIDTH'(3 * NUM_PATTERNS * (NUM_PATTERNS + 1) / 2);
  localparam logic [7:0]           LAST_PATTERN = 8'(NUM_PATTERNS - 1);
  localparam logic [WORD_SIZE-1:0] BIST_WEIGHT  = WORD_SIZE'(3);

  logic [2:0]           state;
  logic [7:0]           pat_cnt;
  logic [WORD_SIZE-1:0] left_in_reg;
  logic [ACC_WIDTH-1:0] top_in_reg;
  logic [WORD_SIZE-1:0] stat_reg;
  logic [ACC_WIDTH-1:0] acc_reg;

  logic                 bist_active;
  logic [WORD_SIZE-1:0] mul_a;
  logic [WORD_SIZE-1:0] mul_b;
  logic [PW-1:0]        product;
  logic [PW-1:0]        fault_prod;
  logic [ACC_WIDTH-1:0] prod_ext;

  // DONE counts as part of self-test, so operands stay frozen and the outputs
  // stay quiet until the FSM returns to IDLE.
  assign bist_active = (state != S_IDLE);
  assign bist_busy   = (state == S_LOAD) || (state == S_RUN) || (state == S_CHECK);
  assign bist_done   = (state == S_DONE);

  // The self-test drives the same multiplier: the operands are (k+1) and
  // stat_reg (= 3), so a fault in the datapath also shows up in the BIST sum.
  assign mul_a    = (state == S_RUN) ? WORD_SIZE'(pat_cnt) + WORD_SIZE'(1) : left_in_reg;
  assign mul_b    = ((state == S_RUN) || stat_mode) ? stat_reg : top_in_reg[WORD_SIZE-1:0];
  assign product  = PW'(mul_a) * PW'(mul_b);
  assign prod_ext = ACC_WIDTH'(fault_prod);

  // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    fault_prod = product;
    if (fi_en) begin
      fault_prod = fi_type ? (product | fi_mask) : (product & ~fi_mask);
    end
  end

  always_comb begin
    right_out  = '0;
    bottom_out = '0;
    if (!bist_active) begin
      right_out = left_in_reg;
      if (bypass || !out_sel) begin
        bottom_out = top_in_reg;
      end else begin
        bottom_out = acc_reg;
      end
    end
  end

  // NOTE: all state uses non-blocking assignments, so every register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      pat_cnt     <= '0;
      left_in_reg <= '0;
      top_in_reg  <= '0;
      stat_reg    <= '0;
      acc_reg     <= '0;
      bist_fail   <= 1'b0;
      bypass      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          left_in_reg <= left_in;
          top_in_reg  <= top_in;
          if (load_stat) begin
            stat_reg <= top_in[WORD_SIZE-1:0];
          end
          if (acc_clear) begin
            acc_reg <= '0;
          end else if (stat_mode) begin
            acc_reg <= prod_ext + top_in_reg;
          end else begin
            acc_reg <= acc_reg + prod_ext;
          end
          if (bist_start) begin
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          stat_reg <= BIST_WEIGHT;
          acc_reg  <= '0;
          pat_cnt  <= '0;
          state    <= S_RUN;
        end
        S_RUN: begin
          acc_reg <= acc_reg + prod_ext;
          pat_cnt <= pat_cnt + 8'd1;
          if (pat_cnt == LAST_PATTERN) begin
            state <= S_CHECK;
          end
        end
        S_CHECK: begin
          bist_fail <= (acc_reg != GOLDEN);
          bypass    <= (acc_reg != GOLDEN);
          // The BIST weight and the sum are not valid operands; the host
          // reloads the stationary value afterwards.
          stat_reg  <= '0;
          acc_reg   <= '0;
          state     <= S_DONE;
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bist_mac_pe.sv
// Directed testbench for bist_mac_pe (default parameters: 16-bit words,
// 32-bit accumulator, 4 BIST patterns). The expected values are hand-computed
// constants.
module tb_bist_mac_pe;

  logic        clk = 1'b0;
  logic        rst;
  logic        stat_mode, load_stat, acc_clear, out_sel;
  logic [15:0] left_in;
  logic [31:0] top_in;
  logic        fi_en, fi_type;
  logic [31:0] fi_mask;
  logic        bist_start;
  logic [15:0] right_out;
  logic [31:0] bottom_out;
  logic        bist_busy, bist_done, bist_fail, bypass;

  int checks = 0;
  int errors = 0;

  int          edges, busy_cycles;
  logic [31:0] acc_chk;
  logic        quiet_fail;

  bist_mac_pe #(.WORD_SIZE(16), .ACC_WIDTH(32), .NUM_PATTERNS(4)) dut (
    .clk(clk), .rst(rst), .stat_mode(stat_mode), .load_stat(load_stat),
    .acc_clear(acc_clear), .out_sel(out_sel), .left_in(left_in), .top_in(top_in),
    .fi_en(fi_en), .fi_type(fi_type), .fi_mask(fi_mask), .bist_start(bist_start),
    .right_out(right_out), .bottom_out(bottom_out), .bist_busy(bist_busy),
    .bist_done(bist_done), .bist_fail(bist_fail), .bypass(bypass)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one self-test from IDLE. Counts edges until bist_done (bounded),
  // counts busy cycles, captures acc_reg while in CHECK, and flags any nonzero
  // output seen while busy. Functional inputs are scrambled to show that they
  // are ignored.
  task automatic run_bist(output int n, output int busy, output logic [31:0] acc_at_check,
                          output logic noisy);
    n = 0;
    busy = 0;
    acc_at_check = 'x;
    noisy = 1'b0;
    bist_start = 1'b1;
    while (n < 40) begin
      tick();
      n++;
      if (n == 1) begin
        bist_start = 1'b0;
        left_in    = 16'hFFFF;
        top_in     = 32'hFFFF_FFFF;
        load_stat  = 1'b1;
      end
      if (bist_busy) begin
        busy++;
        if (right_out !== '0 || bottom_out !== '0) noisy = 1'b1;
      end
      if (dut.state == 3'd3) acc_at_check = dut.acc_reg;
      if (bist_done) break;
    end
    load_stat = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    stat_mode = 0; load_stat = 0; acc_clear = 0; out_sel = 0;
    left_in = 16'hAB; top_in = 32'hCD;
    fi_en = 0; fi_type = 0; fi_mask = '0; bist_start = 0;
    #1 rst = 1'b1;

    // Reset: the registers must stay cleared even while clocks run with nonzero inputs.
    tick(); tick();
    check("rst_right_out", 64'(right_out), 64'h0);
    check("rst_bottom_out", 64'(bottom_out), 64'h0);
    check("rst_status", 64'({bist_busy, bist_done, bist_fail, bypass}), 64'h0);
    @(negedge clk) rst = 1'b0;

    // Weight-stationary: stat=5, then 7*5 + 100 = 135.
    load_stat = 1; top_in = 5;
    tick();
    load_stat = 0; stat_mode = 1; left_in = 7; top_in = 100; out_sel = 1;
    tick(); tick();
    check("ws_bottom_out", 64'(bottom_out), 64'd135);
    check("ws_right_out", 64'(right_out), 64'd7);

    // Output-stationary: the clear wins over accumulation, then 2*3 + 4*5 = 26.
    stat_mode = 0; acc_clear = 1; left_in = 2; top_in = 3;
    tick();
    check("os_clear_priority", 64'(bottom_out), 64'd0);
    acc_clear = 0; left_in = 4; top_in = 5;
    tick();
    check("os_partial", 64'(bottom_out), 64'd6);
    left_in = 0; top_in = 0;
    tick();
    check("os_sum", 64'(bottom_out), 64'd26);
    out_sel = 0; top_in = 32'h55;
    tick();
    check("forward_top_in", 64'(bottom_out), 64'h55);

    // Functional stuck-at-0 on bit 1: the product 2*3=6 becomes 4.
    out_sel = 1; acc_clear = 1; left_in = 2; top_in = 3;
    fi_en = 1; fi_type = 0; fi_mask = 32'h2;
    tick();
    acc_clear = 0; left_in = 0; top_in = 0;
    tick();
    check("func_fault_sa0", 64'(bottom_out), 64'd4);
    fi_en = 0; fi_mask = '0;

    // Wrap: acc = 0xFFFFFFFF through the WS path, then OS + product 1 wraps to 0.
    load_stat = 1; top_in = 0;
    tick();
    load_stat = 0; stat_mode = 1; left_in = 0; top_in = 32'hFFFF_FFFF;
    tick();
    left_in = 1; top_in = 1;
    tick();
    check("wrap_setup", 64'(bottom_out), 64'hFFFF_FFFF);
    stat_mode = 0; left_in = 0; top_in = 0;
    tick();
    check("wrap_to_zero", 64'(bottom_out), 64'h0);

    // Passing self-test: 6 busy cycles, done at edge 7, and the sum 3+6+9+12 = 30.
    left_in = 16'h11; top_in = 32'h22;
    tick();
    run_bist(edges, busy_cycles, acc_chk, quiet_fail);
    check("bist_done_edge", 64'(edges), 64'd7);
    check("bist_busy_cycles", 64'(busy_cycles), 64'd6);
    check("bist_acc_check", 64'(acc_chk), 64'd30);
    check("bist_pass_fail", 64'(bist_fail), 64'd0);
    check("bist_pass_bypass", 64'(bypass), 64'd0);
    check("bist_outputs_quiet", 64'(quiet_fail), 64'd0);
    check("bist_held_left_in", 64'(dut.left_in_reg), 64'h11);
    check("bist_done_clears_acc", 64'({dut.acc_reg, 16'(dut.stat_reg)}), 64'h0);
    tick();
    check("bist_done_one_cycle", 64'(bist_done), 64'd0);

    // Stuck-at-0 on all product bits: the sum is 0, the test fails, and bypass forwards top_in.
    fi_en = 1; fi_type = 0; fi_mask = 32'hFFFF_FFFF;
    run_bist(edges, busy_cycles, acc_chk, quiet_fail);
    check("sa0_acc", 64'(acc_chk), 64'h0);
    check("sa0_fail", 64'(bist_fail), 64'd1);
    check("sa0_bypass", 64'(bypass), 64'd1);
    tick();
    fi_en = 0; out_sel = 1; top_in = 32'h1234; left_in = 16'h77;
    tick();
    check("bypass_bottom_out", 64'(bottom_out), 64'h1234);
    check("bypass_right_out", 64'(right_out), 64'h77);

    // Stuck-at-1 on all bits: 4 * 0xFFFFFFFF wraps to 0xFFFFFFFC, so the test fails.
    fi_en = 1; fi_type = 1; fi_mask = 32'hFFFF_FFFF;
    run_bist(edges, busy_cycles, acc_chk, quiet_fail);
    check("sa1_acc", 64'(acc_chk), 64'hFFFF_FFFC);
    check("sa1_fail", 64'(bist_fail), 64'd1);
    tick();
    fi_en = 0; fi_type = 0; fi_mask = '0;

    // Reset in the middle of RUN: the FSM aborts and fail/bypass are cleared immediately.
    bist_start = 1;
    tick();
    bist_start = 0;
    tick(); tick();
    check("mid_run_busy", 64'(bist_busy), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_outputs", 64'({right_out, bottom_out}), 64'h0);
    check("rst_mid_status", 64'({bist_busy, bist_done, bist_fail, bypass}), 64'h0);
    check("rst_mid_state", 64'(dut.state), 64'd0);
    @(negedge clk) rst = 1'b0;
    tick();

    run_bist(edges, busy_cycles, acc_chk, quiet_fail);
    check("post_rst_done_edge", 64'(edges), 64'd7);
    check("post_rst_acc", 64'(acc_chk), 64'd30);
    check("post_rst_fail", 64'(bist_fail), 64'd0);
    tick();

    // Bypass is cleared only by a passing self-test.
    fi_en = 1; fi_type = 0; fi_mask = 32'hFFFF_FFFF;
    run_bist(edges, busy_cycles, acc_chk, quiet_fail);
    tick();
    fi_en = 0; fi_mask = '0;
    check("bypass_set_again", 64'(bypass), 64'd1);
    run_bist(edges, busy_cycles, acc_chk, quiet_fail);
    check("pass_clears_bypass", 64'({bist_fail, bypass}), 64'd0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bist_mac_pe.md
BIST_MAC_PE -- requirements
Module: bist_mac_pe

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 16, operand width.
REQ-002 SHALL have parameter ACC_WIDTH, default 32, accumulator/partial-sum width; legal range ≥ 2*WORD_SIZE.
REQ-003 SHALL have parameter NUM_PATTERNS, default 4, BIST run length; legal range 1..255.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 stat_mode  input  1  1 = weight/input-stationary, 0 = output-stationary.
REQ-007 load_stat  input  1  load stationary operand from top_in[WORD_SIZE-1:0].
REQ-008 acc_clear  input  1  clear accumulator (OS mode).
REQ-009 out_sel  input  1  0 = bottom_out forwards top_in_reg, 1 = bottom_out shows accumulator.
REQ-010 left_in  input  WORD_SIZE  activation.
REQ-011 top_in  input  ACC_WIDTH  weight / partial sum / operand.
REQ-012 fi_en  input  1  fault injection enable.
REQ-013 fi_type  input  1  0 = stuck-at-0, 1 = stuck-at-1.
REQ-014 fi_mask  input  2*WORD_SIZE  product bits affected.
REQ-015 bist_start  input  1  start self-test (level sampled in IDLE).
REQ-016 right_out  output  WORD_SIZE  registered left_in.
REQ-017 bottom_out  output  ACC_WIDTH  partial sum / forwarded operand.
REQ-018 bist_busy, bist_done, bist_fail, bypass  output  1 each  self-test status.

Function
REQ-019 left_in_reg and top_in_reg SHALL register left_in/top_in every cycle outside BIST; right_out = left_in_reg.
REQ-020 Product SHALL be full 2*WORD_SIZE unsigned: left_in_reg * (stat_mode ? stat_reg : top_in_reg[WORD_SIZE-1:0]).
REQ-021 Fault SHALL apply to product when fi_en=1: fi_type=0 → product & ~fi_mask; fi_type=1 → product | fi_mask; active in functional and BIST operation.
REQ-022 stat_mode=1: acc_reg <= zero-extended faulted product + top_in_reg; stat_mode=0: acc_reg <= acc_reg + product; all sums wrap mod 2^ACC_WIDTH.
REQ-023 acc_clear=1 SHALL set acc_reg to 0 next edge, with priority over accumulation.
REQ-024 load_stat=1 SHALL load stat_reg <= top_in[WORD_SIZE-1:0] same edge (unregistered input), accumulation continues in parallel.
REQ-025 bottom_out = out_sel ? acc_reg : top_in_reg, unless bypass or BIST (REQ-031, REQ-032).
REQ-026 BIST FSM states IDLE, LOAD, RUN, CHECK, DONE; IDLE→LOAD on bist_start; LOAD→RUN; RUN holds NUM_PATTERNS cycles (counter 0..N-1); RUN→CHECK; CHECK→DONE; DONE→IDLE.
REQ-027 LOAD SHALL set stat_reg=3, acc_reg=0; RUN cycle k SHALL accumulate (k+1)*3 via faulted product path, acc += product.
REQ-028 CHECK SHALL compare acc_reg with golden 3*N*(N+1)/2 mod 2^ACC_WIDTH; mismatch sets bist_fail, match clears it; bypass <= bist_fail result on DONE entry.
REQ-029 bist_busy=1 in LOAD/RUN/CHECK; bist_done=1 only in DONE (one cycle); bist_done first high NUM_PATTERNS+3 edges after start sampled.
REQ-030 On DONE, stat_reg and acc_reg SHALL clear to 0; host reloads stationary operand.
REQ-031 During BIST: functional inputs ignored, left_in_reg/top_in_reg held, right_out=0, bottom_out=0; bist_start while busy ignored.
REQ-032 bypass=1: right_out = left_in_reg, bottom_out = top_in_reg regardless of out_sel; cleared only by passing BIST or rst.

Reset
REQ-033 rst SHALL asynchronously zero all registers, FSM→IDLE, bist_fail=bypass=bist_busy=bist_done=0, right_out=0, bottom_out=0; rst mid-BIST aborts with no fail recorded.

Verification
REQ-034 WS: load_stat with top_in=5; then stat_mode=1, left_in=7, top_in=100, out_sel=1 → bottom_out=135 two edges later.
REQ-035 OS: acc_clear; pairs (2,3),(4,5) via left_in/top_in, out_sel=1 → bottom_out=26.
REQ-036 BIST, fi_en=0, N=4 → bist_busy 6 cycles, bist_done at edge 7, bist_fail=0, bypass=0, acc check 30.
REQ-037 BIST, fi_en=1, fi_type=0, fi_mask all-ones → bist_fail=1, bypass=1; then top_in=0x1234 → bottom_out=0x1234 next edge.
REQ-038 Wrap: OS, acc_reg=0xFFFFFFFF, product 1 → acc_reg=0; stuck-at-1 all-ones BIST → acc 0xFFFFFFFC, fail.
REQ-039 rst asserted during RUN → FSM IDLE, all outputs 0 immediately; new bist_start completes normally.
